cdce62002_spi_engine: RTL
=========================

Name: cdce62002_spi_engine

Overview:
- Serial write engine that sits directly downstream of the CDCE62002 control FSM.
- Takes the pass-through config/sleep/wakeup requests from the control FSM and serialises fixed 32-bit register words onto the CDCE62002 three-wire interface (SPI_CLK, SPI_MOSI, SPI_LE).
- Drives the transfer-busy flag back to the control FSM; the falling edge of that flag marks completion.

Parameters:
- CLK_DIV, 4: clk cycles per SPI_CLK half-period; legal range ≥1.
- LE_GAP, 4: clk cycles LE is held high after each word; legal range ≥1.
- REG0_VAL, 32'h0081_4000: register 0 image; bits [3:0] are overridden to 4'h0 on transmit.
- REG1_VAL, 32'h0000_0001: register 1 image; bits [3:0] are overridden to 4'h1 on transmit.
- SLEEP_BIT, 31: bit index inside the REG1 image that forces power-down; legal range 4..31.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- i_config, input, 1: config request from the control FSM. Rising edge triggers a transfer.
- i_sleep, input, 1: power-down request. Rising edge triggers a transfer.
- i_wakeup, input, 1: wake-up request. Rising edge triggers a transfer.
- o_tran_busy, output, 1: high while a sequence is in progress.
- o_spi_clk, output, 1: serial clock to the device; idles low.
- o_spi_mosi, output, 1: serial data, sent LSB first.
- o_spi_le, output, 1: latch enable; idles high, low while shifting.
- o_word_cnt, output, 2: number of words completed in the current or most recent sequence.

Behaviour:
- Reset (synchronous, active-high): o_tran_busy=0, o_spi_clk=0, o_spi_mosi=0, o_spi_le=1, o_word_cnt=0, FSM=IDLE, request edge-detect registers=0.
  - Reset asserted mid-transfer aborts the transfer on the next edge; LE returns high and no partial word is latched.
- Edge detect: each request input is registered once. A request is the cycle where the input is 1 and its registered copy is 0.
  - Edges arriving outside IDLE are discarded; they are not queued.
- Simultaneous edges are resolved by priority config > sleep > wakeup. Lower-priority edges in the same cycle are discarded.
- Sequences:
  - config: REG0 word, then REG1 word.
  - sleep: one word, REG1 with SLEEP_BIT=1.
  - wakeup: one word, REG1 with SLEEP_BIT=0.
- Word assembly: {image[31:4], addr[3:0]}. Address nibble is forced to 0 or 1 regardless of the parameter value.
- FSM states:
  - IDLE → SHIFT on an accepted edge at cycle N.
  - SHIFT → GAP after the 32nd bit.
  - GAP → SHIFT if words remain in the sequence.
  - GAP → IDLE when the last word is done.
- Accept timing (edge at cycle N): at N+1, o_tran_busy=1, o_spi_le=0, o_spi_mosi=bit0, o_spi_clk=0, o_word_cnt=0.
- Bit timing:
  - Each bit occupies 2*CLK_DIV cycles: SPI_CLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MOSI changes only on the cycle SPI_CLK falls (or at word start). It is stable across the rising edge.
  - One word = 64*CLK_DIV cycles.
- GAP timing:
  - Cycle after the last high half of bit 31: SPI_CLK=0, LE=1, o_word_cnt increments.
  - LE stays high for LE_GAP cycles.
  - If another word follows, LE falls and bit0 of that word is presented in the next cycle.
- Busy timing: o_tran_busy falls in the cycle after the final GAP ends. Total busy duration = W*(64*CLK_DIV+LE_GAP) cycles, W = 1 or 2.
- Divider and bit counter are internal:
  - Bit counter is 5 bits and terminates at 31.
  - Divider counts 0..CLK_DIV-1.
  - No wrap-around beyond a word.
- o_word_cnt holds its value in IDLE and clears when the next sequence is accepted.

Test Plan:
- Reset then idle, CLK_DIV=2, LE_GAP=4: hold 20 cycles with no request → busy=0, le=1, spi_clk=0, mosi=0 throughout.
- Wakeup pulse, REG1_VAL=32'h8000_00F5, SLEEP_BIT=31:
  - Captured word = 32'h0000_00F1, LSB first, sampled on SPI_CLK rising edges.
  - Busy high exactly 132 cycles; 32 SPI_CLK rising edges; o_word_cnt=1.
- Sleep pulse, REG1_VAL=32'h0000_0000 → captured word 32'h8000_0001; le low for 128 cycles then high.
- Config pulse, REG0_VAL=32'h1234_567F, REG1_VAL=32'hABCD_EF00:
  - Words 32'h1234_5670 then 32'hABCD_EF01.
  - LE high 4 cycles between words; busy 264 cycles; o_word_cnt=2.
- Overlap cases:
  - Config and sleep rising in the same cycle → only the config sequence runs (2 words).
  - Wakeup pulse during busy → ignored; busy falls on schedule and no extra word follows.
- Reset asserted at bit 10 of a config word → next cycle le=1, busy=0, spi_clk=0. A following wakeup runs normally from bit0.

Source files
------------

// File: rtl/cdce62002_spi_engine.sv
// Serial write engine for the CDCE62002 three-wire interface: turns config/sleep/wakeup
// request edges into one or two 32-bit register writes, LSB first, framed by LE.
module cdce62002_spi_engine #(
    parameter int          CLK_DIV   = 4,
    parameter int          LE_GAP    = 4,
    parameter logic [31:0] REG0_VAL  = 32'h0081_4000,
    parameter logic [31:0] REG1_VAL  = 32'h0000_0001,
    parameter int          SLEEP_BIT = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_config,
    input  logic       i_sleep,
    input  logic       i_wakeup,
    output logic       o_tran_busy,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    output logic       o_spi_le,
    output logic [1:0] o_word_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (LE_GAP > 1) ? $clog2(LE_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LE_GAP - 1);

    // Address nibble is forced regardless of what the images carry.
    localparam logic [31:0] REG0_WORD  = {REG0_VAL[31:4], 4'h0};
    localparam logic [31:0] REG1_WORD  = {REG1_VAL[31:4], 4'h1};
    localparam logic [31:0] SLEEP_MASK = 32'h1 << SLEEP_BIT;
    localparam logic [31:0] SLEEP_WORD = REG1_WORD | SLEEP_MASK;
    localparam logic [31:0] WAKE_WORD  = REG1_WORD & ~SLEEP_MASK;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [2:0]       req_in;
    logic [2:0]       req_d_reg;
    logic [2:0]       req_edge;
    logic [31:0]      shift_reg;
    logic [31:0]      next_word_reg;
    logic             words_left_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic             phase_hi_reg;
    logic [4:0]       bit_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [1:0]       word_cnt_reg;

    logic accept;
    logic half_end;
    logic bit_end;
    logic word_end;
    logic gap_end;

    // Index 2 = config, 1 = sleep, 0 = wakeup; higher index wins on a tie.
    assign req_in = {i_config, i_sleep, i_wakeup};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            always_ff @(posedge clk) begin
                if (rst) begin
                    req_d_reg[gi] <= 1'b0;
                end else begin
                    req_d_reg[gi] <= req_in[gi];
                end
            end
            assign req_edge[gi] = req_in[gi] & ~req_d_reg[gi];
        end
    endgenerate

    assign accept   = (state_reg == IDLE) && (req_edge != 3'b000);
    assign half_end = (div_cnt_reg == DIV_LAST);
    assign bit_end  = half_end && phase_hi_reg;
    assign word_end = bit_end && (bit_cnt_reg == 5'd31);
    assign gap_end  = (gap_cnt_reg == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (word_end) state_next = GAP;
            GAP:     if (gap_end) state_next = words_left_reg ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg      <= '0;
            next_word_reg  <= '0;
            words_left_reg <= 1'b0;
            div_cnt_reg    <= '0;
            phase_hi_reg   <= 1'b0;
            bit_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (req_edge[2]) begin
                            shift_reg <= REG0_WORD;
                        end else if (req_edge[1]) begin
                            shift_reg <= SLEEP_WORD;
                        end else begin
                            shift_reg <= WAKE_WORD;
                        end
                        next_word_reg  <= REG1_WORD;
                        words_left_reg <= req_edge[2];
                        div_cnt_reg    <= '0;
                        phase_hi_reg   <= 1'b0;
                        bit_cnt_reg    <= '0;
                        word_cnt_reg   <= '0;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        div_cnt_reg  <= '0;
                        phase_hi_reg <= ~phase_hi_reg;
                        if (word_end) begin
                            gap_cnt_reg  <= '0;
                            word_cnt_reg <= word_cnt_reg + 2'd1;
                        end else if (bit_end) begin
                            // Data advances only as SPI_CLK falls.
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            shift_reg   <= shift_reg >> 1;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                GAP: begin
                    gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    if (gap_end && words_left_reg) begin
                        shift_reg      <= next_word_reg;
                        words_left_reg <= 1'b0;
                        div_cnt_reg    <= '0;
                        phase_hi_reg   <= 1'b0;
                        bit_cnt_reg    <= '0;
                    end
                end
                default: begin
                    words_left_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_tran_busy = (state_reg != IDLE);
        o_spi_clk   = (state_reg == SHIFT) && phase_hi_reg;
        o_spi_le    = (state_reg != SHIFT);
        o_spi_mosi  = (state_reg == SHIFT) && shift_reg[0];
        o_word_cnt  = word_cnt_reg;
    end

endmodule
